// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling factor and divider
// computation, intended for reuse by a future uart_tx.
`ifndef UART_DIV
`define UART_DIV(f, b) ((f) / ((b) * 16))
`endif

package uart_rx_pkg;

    localparam int OS = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    // Clocks per oversample tick, integer floor; callers must keep the result >= 1.
    function automatic int uart_div(input int f, input int b);
        return `UART_DIV(f, b);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks (16x the baud rate).
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    // A one-bit counter is kept even when DIV=1 so the width never collapses to zero.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with valid/ack byte handshake and error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int clk_freq = 50000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int DIV = uart_div(clk_freq, baud);

    logic        tick;
    logic [1:0]  sync_q;
    logic        rx_s;

    uart_state_e state_q, state_d;
    logic [3:0]  sc_q, sc_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        deliver;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Synchroniser resets to the idle-high level so release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx};
    end
    assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_set;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case statement,
        // so no path can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        sc_d        = sc_q + 4'd1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
        perr_set    = 1'b0;
`endif
        if (!tick) sc_d = sc_q;

        case (state_q)
            ST_IDLE: begin
                sc_d = 4'd0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (tick && sc_q == 4'd7) begin
                    sc_d  = 4'd0;
                    bit_d = 3'd0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && sc_q == 4'd15) begin
                    shift_d[bit_q] = rx_s;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick && sc_q == 4'd15) begin
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick && sc_q == 4'd15) begin
                    if (rx_s) begin
                        deliver = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_set = (par_q != ^shift_q);
`endif
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                sc_d = 4'd0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An ack coinciding with a delivery frees the register for the new byte.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (deliver) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sc_q        <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= perr_set;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DIV=1 (16 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    time start_t = 0;
    time rise_t = 0;
    logic valid_prev = 1'b0;

    uart_rx #(.clk_freq(50000000), .baud(3125000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
        if (parity_err) pe_cnt++;
        if (rx_valid && !valid_prev) rise_t = $time;
        valid_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame on negedges; rx_ack is raised for exactly the cycle the
    // receiver completes the stop bit when ack_on_deliver is set.
    task automatic send(input logic [7:0] d, input logic stop_bit,
                        input bit with_par, input logic par_bit, input bit ack_on_deliver);
        @(negedge clk);
        rx = 1'b0;
        start_t = $time;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = d[i];
            repeat (15) @(negedge clk);
        end
        if (with_par) begin
            @(negedge clk);
            rx = par_bit;
            repeat (15) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) rx = stop_bit;
            rx_ack = ack_on_deliver && (i == 10);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    bit wp;

    initial begin
`ifdef UART_RX_PARITY_EN
        wp = 1'b1;
`else
        wp = 1'b0;
`endif
        // Reset with line idle.
        repeat (4) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_valid", rx_valid, 0);

        // 0x55 (four ones: even parity bit 0).
        send(8'h55, 1'b1, wp, 1'b0, 1'b0);
        check("b55_valid", rx_valid, 1);
        check("b55_data", rx_data, 8'h55);
        check("b55_latency_ok", ((rise_t - start_t) / 10) <= 165, 1);
        repeat (50) @(negedge clk);
        check("b55_hold_valid", rx_valid, 1);
        check("b55_hold_data", rx_data, 8'h55);
        ack_pulse();
        check("b55_ack_clears", rx_valid, 0);

        // Short glitch on idle line.
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", rx_valid, 0);
        check("glitch_frame_err", fe_cnt, 0);

        // 0xA3 (four ones) with a bad stop bit, then a long low line.
        send(8'hA3, 1'b0, wp, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("a3_frame_err", fe_cnt, 1);
        check("a3_valid", rx_valid, 0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("break_no_retrigger", fe_cnt, 1);
        send(8'h3C, 1'b1, wp, 1'b0, 1'b0);
        check("b3c_valid", rx_valid, 1);
        check("b3c_data", rx_data, 8'h3C);
        ack_pulse();

        // Overrun: second byte dropped.
        send(8'h11, 1'b1, wp, 1'b0, 1'b0);
        send(8'h22, 1'b1, wp, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("ovr_pulse", ov_cnt, 1);
        check("ovr_keep_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        ack_pulse();
        check("ovr_ack_clears", rx_valid, 0);

        // Ack coincident with delivery: new byte replaces old, no overrun.
        send(8'h11, 1'b1, wp, 1'b0, 1'b0);
        send(8'h22, 1'b1, wp, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("ackdel_data", rx_data, 8'h22);
        check("ackdel_valid", rx_valid, 1);
        check("ackdel_no_overrun", ov_cnt, 1);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: correct even parity bit is 1.
        send(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_bad_pulse", pe_cnt, 1);
        check("par_bad_data", rx_data, 8'h07);
        check("par_bad_valid", rx_valid, 1);
        ack_pulse();
        send(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        check("par_good_no_pulse", pe_cnt, 1);
        check("par_good_data", rx_data, 8'h07);
        ack_pulse();
`else
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        check("nopar_data", rx_data, 8'h07);
        check("nopar_never_err", pe_cnt, 0);
        ack_pulse();
`endif

        // Reset during a frame aborts it silently.
        @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst_valid", rx_valid, 0);
        check("midrst_frame_err", frame_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
